// File: rtl/sba_uart_master.sv
// Host-facing SBA bus initiator: decodes 'W'/'R' byte commands from the UART
// receive path, runs one 32-bit bus transaction, and streams the response bytes back.
module sba_uart_master #(
  parameter int BUS_TIMEOUT = 1024,
  parameter int RX_TIMEOUT  = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_dat,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_dat,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_addr,
  output logic [31:0] o_dat_w,
  output logic [3:0]  o_we,
  output logic        o_stb,
  input  logic [31:0] i_dat_r,
  input  logic        i_ack,
  output logic        o_busy
);

  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam int RW = $clog2(RX_TIMEOUT + 1);
  localparam logic [BW-1:0] BUS_LAST = BW'(BUS_TIMEOUT - 1);
  localparam logic [RW-1:0] RX_LAST  = RW'(RX_TIMEOUT - 1);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK_B = 8'h06;
  localparam logic [7:0] NAK_B = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS, S_GAP, S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdat_q, wdat_d;
  logic [BW-1:0]  bus_tmo_q, bus_tmo_d;
  logic [RW-1:0]  rx_tmo_q, rx_tmo_d;
  logic [31:0]    resp_q, resp_d;
  logic [2:0]     left_q, left_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      bus_tmo_q <= '0;
      rx_tmo_q  <= '0;
      resp_q    <= '0;
      left_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      bus_tmo_q <= bus_tmo_d;
      rx_tmo_q  <= rx_tmo_d;
      resp_q    <= resp_d;
      left_q    <= left_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    bus_tmo_d = bus_tmo_q;
    rx_tmo_d  = rx_tmo_q;
    resp_d    = resp_q;
    left_d    = left_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_dat == CMD_W || i_rx_dat == CMD_R) begin
            state_d  = S_ADDR;
            cnt_d    = '0;
            wr_d     = (i_rx_dat == CMD_W);
            rx_tmo_d = '0;
          end else begin
            state_d = S_RESP;
            resp_d  = {24'h0, NAK_B};
            left_d  = 3'd1;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (i_rx_valid) begin
          rx_tmo_d = '0;
          cnt_d    = cnt_q + 2'd1;
          if (state_q == S_ADDR) addr_d[{cnt_q, 3'b000} +: 8] = i_rx_dat;
          else                   wdat_d[{cnt_q, 3'b000} +: 8] = i_rx_dat;
          if (cnt_q == 2'd3) begin
            bus_tmo_d = '0;
            state_d   = (state_q == S_ADDR && wr_q) ? S_DATA : S_BUS;
          end
        end else if (rx_tmo_q == RX_LAST) begin
          // Host went quiet mid-command: drop it without a reply.
          state_d = S_IDLE;
        end else begin
          rx_tmo_d = rx_tmo_q + 1'b1;
        end
      end
      S_BUS: begin
        if (i_ack) begin
          state_d = S_GAP;
          if (wr_q) begin
            resp_d = {24'h0, ACK_B};
            left_d = 3'd1;
          end else begin
            resp_d = i_dat_r;
            left_d = 3'd4;
          end
        end else if (bus_tmo_q == BUS_LAST) begin
          state_d = S_GAP;
          resp_d  = {24'h0, NAK_B};
          left_d  = 3'd1;
        end else begin
          bus_tmo_d = bus_tmo_q + 1'b1;
        end
      end
      // One dead cycle swallows a registered ack still in flight.
      S_GAP: state_d = S_RESP;
      S_RESP: begin
        if (i_tx_ready) begin
          resp_d = {8'h0, resp_q[31:8]};
          left_d = left_q - 3'd1;
          if (left_q == 3'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_addr     = addr_q;
  assign o_dat_w    = wdat_q;
  assign o_stb      = (state_q == S_BUS);
  assign o_we       = (state_q == S_BUS && wr_q) ? 4'b1111 : 4'b0000;
  assign o_tx_valid = (state_q == S_RESP);
  assign o_tx_dat   = (state_q == S_RESP) ? resp_q[7:0] : 8'h00;
  assign o_busy     = (state_q != S_IDLE);

endmodule
